// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the segment scan driver
package seg_scan_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  typedef logic [7:0] seg_t;
  localparam seg_t SEG_BLANK = 8'hFF;
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: frame offer handshake between a frame source and the scan driver
interface seg_scan_if #(parameter int P_NO_DIGITS = 8);
  import seg_scan_pkg::*;
  seg_t [P_NO_DIGITS-1:0] frame_in;
  logic frame_valid;
  logic frame_ready;
  modport master (output frame_in, frame_valid, input frame_ready);
  modport slave (input frame_in, frame_valid, output frame_ready);
endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: blank/dwell phase counter with brightness PWM compare
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int P_DWELL_CYCLES = 1024,
  parameter int P_BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  state_t     state,
  input  logic [3:0] brightness,
  output logic       phase_done,
  output logic       lit
);
  localparam int MAXC = P_DWELL_CYCLES > P_BLANK_CYCLES ? P_DWELL_CYCLES : P_BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] b_q, b_d;
  // Phase end detection, counter advance, brightness latch on BLANK->ON and duty compare
  always_comb begin
    phase_done = state == ON ? cnt_q == CW'(P_DWELL_CYCLES - 1)
                             : state == BLANK && cnt_q == CW'(P_BLANK_CYCLES - 1);
    cnt_d = (!enable || state == IDLE || phase_done) ? '0 : cnt_q + CW'(1);
    b_d = (enable && state == BLANK && phase_done) ? brightness : b_q;
    lit = 32'(cnt_q) < (32'(b_q) + 32'd1) * 32'(P_DWELL_CYCLES / 16);
  end
  // Counter and latched brightness registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      b_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      b_q <= b_d;
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with double-buffered frames and PWM dimming
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int P_NO_DIGITS    = 8,
  parameter int P_DWELL_CYCLES = 1024,
  parameter int P_BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  seg_scan_if.slave              fbus,
  input  logic [3:0]             brightness,
  input  logic [P_NO_DIGITS-1:0] digit_mask,
  output logic [7:0]             seg_n,
  output logic [P_NO_DIGITS-1:0] an_n,
  output logic                   frame_start
);
  localparam int IW = P_NO_DIGITS > 1 ? $clog2(P_NO_DIGITS) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  seg_t [P_NO_DIGITS-1:0] pend_q, pend_d, shadow_q, shadow_d;
  logic pend_full_q, pend_full_d;
  seg_t seg_n_q, seg_n_d;
  logic [P_NO_DIGITS-1:0] an_n_q, an_n_d;
  logic frame_start_q, frame_start_d;
  logic phase_done, lit, last, boundary, swap, accept, drive;

  seg_scan_timer #(
    .P_DWELL_CYCLES(P_DWELL_CYCLES),
    .P_BLANK_CYCLES(P_BLANK_CYCLES)
  ) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .state(state_q),
    .brightness(brightness),
    .phase_done(phase_done),
    .lit(lit)
  );

  assign fbus.frame_ready = !pend_full_q;
  assign seg_n = seg_n_q;
  assign an_n = an_n_q;
  assign frame_start = frame_start_q;

  // Frame buffering, scan sequencing and next output values
  always_comb begin
    accept = fbus.frame_valid && !pend_full_q;
    last = idx_q == IW'(P_NO_DIGITS - 1);
    boundary = enable && (state_q == IDLE || (state_q == ON && phase_done && last));
    swap = boundary && pend_full_q;
    pend_d = accept ? fbus.frame_in : pend_q;
    pend_full_d = accept || (pend_full_q && !swap);
    shadow_d = swap ? pend_q : shadow_q;
    state_d = !enable ? IDLE
            : state_q == IDLE ? BLANK
            : phase_done ? (state_q == BLANK ? ON : BLANK)
            : state_q;
    idx_d = (!enable || state_q == IDLE) ? '0
          : (state_q == ON && phase_done) ? (last ? '0 : idx_q + IW'(1))
          : idx_q;
    drive = state_q == ON && lit && digit_mask[idx_q];
    an_n_d = drive ? ~(P_NO_DIGITS'(1) << idx_q) : '1;
    seg_n_d = drive ? shadow_q[idx_q] : SEG_BLANK;
    frame_start_d = swap;
  end

  // State, frame buffers and registered display outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      pend_q <= '{default: SEG_BLANK};
      pend_full_q <= 1'b0;
      shadow_q <= '{default: SEG_BLANK};
      seg_n_q <= SEG_BLANK;
      an_n_q <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      pend_full_q <= pend_full_d;
      shadow_q <= shadow_d;
      seg_n_q <= seg_n_d;
      an_n_q <= an_n_d;
      frame_start_q <= frame_start_d;
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;
  localparam int N = 8;
  localparam int DW = 32;
  localparam int BL = 2;
  localparam int SLOT = DW + BL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [3:0] brightness = 4'd15;
  logic [N-1:0] digit_mask = '1;
  logic [7:0] seg_n;
  logic [N-1:0] an_n;
  logic frame_start;

  seg_scan_if #(.P_NO_DIGITS(N)) fif ();

  seg_scan_driver #(
    .P_NO_DIGITS(N),
    .P_DWELL_CYCLES(DW),
    .P_BLANK_CYCLES(BL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .fbus(fif.slave),
    .brightness(brightness),
    .digit_mask(digit_mask),
    .seg_n(seg_n),
    .an_n(an_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [7:0] frames [4][N] = '{
    '{default: 8'hFF},
    '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'h08, 8'h08, 8'h08},
    '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8},
    '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E}
  };
  logic [7:0] exp_frame [N];
  int n_assert = 0;
  int n_fail = 0;
  int samp, seg_err, oh_err, fs_cnt, fs_first;
  int lit_cnt [N];
  int first_lit [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    samp = 0; seg_err = 0; oh_err = 0; fs_cnt = 0; fs_first = 0;
    for (int i = 0; i < N; i++) begin
      lit_cnt[i] = 0;
      first_lit[i] = 0;
    end
  endtask

  task automatic set_exp(input int k);
    for (int i = 0; i < N; i++) exp_frame[i] = frames[k][i];
  endtask

  task automatic set_frame_in(input int k);
    for (int i = 0; i < N; i++) fif.frame_in[i] = frames[k][i];
  endtask

  task automatic tick();
    int z, zi;
    @(posedge clk);
    #1;
    samp++;
    z = 0; zi = 0;
    for (int i = 0; i < N; i++)
      if (an_n[i] !== 1'b1) begin
        z++;
        zi = i;
      end
    if (z > 1) oh_err++;
    else if (z == 1) begin
      lit_cnt[zi]++;
      if (first_lit[zi] == 0) first_lit[zi] = samp;
      if (seg_n !== exp_frame[zi]) seg_err++;
    end else if (seg_n !== 8'hFF) seg_err++;
    if (frame_start === 1'b1) begin
      fs_cnt++;
      if (fs_first == 0) fs_first = samp;
    end else if (frame_start !== 1'b0) fs_cnt += 100;
  endtask

  task automatic run_to(input int n);
    while (samp < n) tick();
  endtask

  task automatic start_scan();
    enable = 1'b0;
    tick();
    tick();
    clear_stats();
    enable = 1'b1;
  endtask

  task automatic check_slots(input string tag, input int len, input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_lit%0d", tag, i), lit_cnt[i], m[i] ? len : 0);
      chk($sformatf("%s_first%0d", tag, i), first_lit[i], m[i] ? 4 + SLOT * i : 0);
    end
    chk({tag, "_seg"}, seg_err, 0);
    chk({tag, "_onehot"}, oh_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fif.frame_valid = 1'b0;
    fif.frame_in = '1;
    clear_stats();
    set_exp(0);
    #22;
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_an", an_n, 8'hFF);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", fif.frame_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_no_scan", an_n, 8'hFF);

    start_scan();
    run_to(275);
    check_slots("blank", 32, 8'hFF);
    chk("blank_fs", fs_cnt, 0);

    enable = 1'b0;
    tick();
    tick();
    set_frame_in(1);
    fif.frame_valid = 1'b1;
    tick();
    fif.frame_valid = 1'b0;
    chk("f1_captured_ready", fif.frame_ready, 0);
    start_scan();
    set_exp(1);
    run_to(275);
    check_slots("f1", 32, 8'hFF);
    chk("f1_fs_cnt", fs_cnt, 1);
    chk("f1_fs_first", fs_first, 1);
    chk("f1_ready_after", fif.frame_ready, 1);
    run_to(276);
    chk("f1_wrap_an", an_n, 8'hFE);

    brightness = 4'd0;
    start_scan();
    run_to(275);
    check_slots("dim", 2, 8'hFF);
    run_to(276);
    chk("dim_period_an", an_n, 8'hFE);
    run_to(278);
    chk("dim_dark_an", an_n, 8'hFF);

    brightness = 4'd15;
    digit_mask = 8'hF0;
    start_scan();
    run_to(275);
    check_slots("mask", 32, 8'hF0);
    digit_mask = '1;

    start_scan();
    run_to(50);
    set_frame_in(2);
    fif.frame_valid = 1'b1;
    tick();
    chk("f2_captured_ready", fif.frame_ready, 0);
    set_frame_in(3);
    run_to(56);
    chk("f3_held_off", fif.frame_ready, 0);
    fif.frame_valid = 1'b0;
    run_to(272);
    chk("f2_no_early_fs", fs_cnt, 0);
    chk("f2_no_early_seg", seg_err, 0);
    tick();
    chk("f2_fs_boundary", frame_start, 1);
    set_exp(2);
    run_to(276);
    chk("f2_first_seg", seg_n, 8'hC0);
    run_to(548);
    chk("f2_seg", seg_err, 0);
    chk("f2_fs_total", fs_cnt, 1);
    chk("f2_onehot", oh_err, 0);
    chk("f2_ready_after", fif.frame_ready, 1);

    start_scan();
    run_to(100);
    chk("arst_pre_an", an_n, 8'hFB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", seg_n, 8'hFF);
    chk("arst_an", an_n, 8'hFF);
    chk("arst_fs", frame_start, 0);
    chk("arst_ready", fif.frame_ready, 1);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    set_exp(0);
    start_scan();
    run_to(140);
    chk("arst_shadow_blank_seg", seg_err, 0);
    chk("arst_digit0_lit", lit_cnt[0], 32);

    run_to(150);
    chk("drop_pre_an", an_n, 8'hEF);
    enable = 1'b0;
    tick();
    chk("drop_latency_an", an_n, 8'hEF);
    tick();
    chk("drop_idle_an", an_n, 8'hFF);
    clear_stats();
    enable = 1'b1;
    run_to(40);
    chk("restart_first0", first_lit[0], 4);
    chk("restart_lit0", lit_cnt[0], 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- P_NO_DIGITS, 8, digits scanned.
- P_DWELL_CYCLES, 1024, ON-phase length per digit; multiple of 16.
- P_BLANK_CYCLES, 16, anti-ghost blank before each digit; >=1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, scan run.
- frame_in, in, P_NO_DIGITS x 8, segment patterns; active-low, bit7 = dp, index 0 = leftmost digit.
- frame_valid, in, 1, frame_in offered.
- frame_ready, out, 1, pending slot free.
- brightness, in, 4, duty level 0..15.
- digit_mask, in, P_NO_DIGITS, 1 = digit may light.
- seg_n, out, 8, segment bus, active-low.
- an_n, out, P_NO_DIGITS, anode selects, active-low.
- frame_start, out, 1, one-cycle pulse at shadow swap.

Function
REQ-003 Frame storage SHALL be a pending register plus a shadow register; the display SHALL only ever show the shadow.
REQ-004 frame_ready SHALL equal NOT pending_full; a frame_valid AND frame_ready cycle SHALL capture frame_in into pending and set pending_full.
REQ-005 Swap SHALL occur at each frame boundary: the IDLE->BLANK exit, or the end of the ON phase of digit P_NO_DIGITS-1. If pending_full, pending SHALL be copied to shadow, pending_full cleared, and frame_start pulsed for 1 cycle.
REQ-006 The FSM SHALL have three states, IDLE, BLANK and ON, with these transitions:
- IDLE->BLANK(digit 0) when enable=1.
- BLANK->ON after P_BLANK_CYCLES cycles.
- ON->BLANK(next digit) after P_DWELL_CYCLES cycles; the digit index wraps from P_NO_DIGITS-1 to 0.
REQ-007 enable=0 in any state SHALL force IDLE on the next edge and clear the digit index and counters; pending SHALL be retained.
REQ-008 brightness SHALL be sampled on BLANK->ON entry as b; during ON, the digit is lit iff dwell_cnt < (b+1)*(P_DWELL_CYCLES/16).
REQ-009 A digit SHALL drive an_n[idx]=0 only when the FSM is in ON, the digit is lit, and digit_mask[idx]=1; otherwise all an_n SHALL be 1 and seg_n SHALL be 8'hFF.
REQ-010 While a digit is driven, seg_n SHALL equal shadow[idx].
REQ-011 Masked digits and dark PWM time SHALL still consume their full slot, so the frame period is constant at P_NO_DIGITS*(P_BLANK_CYCLES+P_DWELL_CYCLES) cycles.
REQ-012 seg_n, an_n and frame_start SHALL be registered, with exactly 1 cycle of latency from the state/counter values.
REQ-013 At most one an_n bit SHALL be 0 in any cycle.
REQ-014 frame_valid on the same cycle as a swap SHALL be refused (frame_ready=0 that cycle if pending was full). If pending was empty, the frame SHALL be captured into pending for the next boundary.

Reset
REQ-015 rst_n=0 SHALL immediately clear the following, regardless of the FSM state at assertion:
- FSM to IDLE; digit index and counters to 0.
- pending_full to 0; shadow to all 8'hFF.
- Outputs: seg_n=8'hFF, an_n all 1, frame_start=0, frame_ready=1.
REQ-016 After rst_n release, the first scan SHALL start only when enable=1.

Structure
REQ-017 Package seg_scan_pkg SHALL hold the state enum, SEG_BLANK=8'hFF and the digit-pattern type (logic [7:0]).
REQ-018 The dwell/blank counter and PWM compare SHALL be a sub-module seg_scan_timer, which outputs phase_done and lit.

Verification
All scenarios use P_NO_DIGITS=8, P_DWELL_CYCLES=32, P_BLANK_CYCLES=2 (period 272 cycles).
REQ-019 Reset, then enable=1 with no frame: an_n walks digits 0..7, and seg_n=8'hFF throughout.
REQ-020 Frame {89,86,C7,C7,C0,08,08,08}, brightness=15:
- frame_start pulses once.
- Digit i shows an_n=~(1<<i) with its pattern for 32 cycles.
- Digits are separated by 2 cycles of all-high an_n.
REQ-021 brightness=0: each digit is lit 2 cycles, then dark 30 cycles; the period stays 272.
REQ-022 Second frame offered mid-frame:
- It is captured and frame_ready drops.
- A third frame_valid is held off.
- The display changes only at the next boundary, with a frame_start pulse.
REQ-023 digit_mask=8'hF0: digits 0-3 never drive an_n low, and the timing of digits 4-7 is unchanged.
REQ-024 Asynchronous reset and enable drop:
- rst_n asserted mid-ON: seg_n=FF and an_n=FF before the next edge; the shadow is blank after release.
- enable dropped mid-scan: IDLE one cycle later.
